// File: rtl/uart_tx_8n1.sv
// uart_tx_8n1: 8N1 UART transmitter clocked by i_clk, paced by an external
// divided baud clock that is synchronised and edge-detected into a bit tick.
// Bytes arrive on a valid/ready handshake; bits leave LSB first on o_tx.
// Build option: define UART_TX_PARITY_EN to insert an even parity bit
// between the last data bit and the stop bit (11-period frame).
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | line high, o_ready follows i_enable, waiting for a byte
// S_WAIT  | byte latched, waiting for the next tick to begin the start bit
// S_START | start bit (0) on the line
// S_DATA  | data bits on the line, shifted out LSB first
// S_PARITY| even parity bit on the line (UART_TX_PARITY_EN only)
// S_STOP  | stop bit (1) on the line; o_done pulses when it ends

module uart_tx_8n1 (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_enable,
   input  logic       i_baud_clk,
   input  logic [7:0] i_data,
   input  logic       i_valid,
   output logic       o_ready,
   output logic       o_tx,
   output logic       o_busy,
   output logic       o_done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_START,
      S_DATA,
`ifdef UART_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   state_t     state_q, state_d;
   logic       sync1_q, sync1_d;
   logic       sync2_q, sync2_d;
   logic       delay_q, delay_d;
   logic [7:0] shift_q, shift_d;
   logic [2:0] cnt_q, cnt_d;
   logic       tx_q, tx_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       rdy_q, rdy_d;
`ifdef UART_TX_PARITY_EN
   logic       parity_q, parity_d;
`endif

   logic tick;
   logic accept;

   assign tick    = sync2_q & ~delay_q;
   assign o_ready = rdy_q & i_enable;
   assign accept  = i_valid & o_ready;
   assign o_tx    = tx_q;
   assign o_busy  = busy_q;
   assign o_done  = done_q;

   // Next-state logic: baud edge detect, frame sequencing and line value.
   always_comb begin
      sync1_d  = i_baud_clk;
      sync2_d  = sync1_q;
      delay_d  = sync2_q;
      state_d  = state_q;
      shift_d  = shift_q;
      cnt_d    = cnt_q;
      tx_d     = tx_q;
      done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d = parity_q;
`endif
      if (!i_enable) begin
         // Abort: drop the frame, line back to idle, no completion pulse.
         state_d = S_IDLE;
         tx_d    = 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               tx_d = 1'b1;
               if (accept) begin
                  shift_d  = i_data;
                  cnt_d    = 3'd0;
                  state_d  = S_WAIT;
`ifdef UART_TX_PARITY_EN
                  parity_d = ^i_data;
`endif
               end
            end
            S_WAIT: begin
               if (tick) begin
                  state_d = S_START;
                  tx_d    = 1'b0;
               end
            end
            S_START: begin
               if (tick) begin
                  state_d = S_DATA;
                  tx_d    = shift_q[0];
               end
            end
            S_DATA: begin
               if (tick) begin
                  if (cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     state_d = S_PARITY;
                     tx_d    = parity_q;
`else
                     state_d = S_STOP;
                     tx_d    = 1'b1;
`endif
                  end else begin
                     // Next bit is shift_q[1]; present it as we shift.
                     shift_d = {1'b0, shift_q[7:1]};
                     cnt_d   = cnt_q + 3'd1;
                     tx_d    = shift_q[1];
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               if (tick) begin
                  state_d = S_STOP;
                  tx_d    = 1'b1;
               end
            end
`endif
            S_STOP: begin
               if (tick) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end
            default: begin
               state_d = S_IDLE;
               tx_d    = 1'b1;
            end
         endcase
      end
      busy_d = (state_d != S_IDLE);
      // Ready only after a full cycle in idle, so it trails o_done by one.
      rdy_d  = (state_q == S_IDLE) && (state_d == S_IDLE);
   end

   // State and registered outputs, synchronous active-high reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         delay_q  <= 1'b0;
         state_q  <= S_IDLE;
         shift_q  <= 8'h00;
         cnt_q    <= 3'd0;
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         rdy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         delay_q  <= delay_d;
         state_q  <= state_d;
         shift_q  <= shift_d;
         cnt_q    <= cnt_d;
         tx_q     <= tx_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         rdy_q    <= rdy_d;
`ifdef UART_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx_8n1.sv
// tb_uart_tx_8n1: directed bench for uart_tx_8n1 with a 434-cycle baud clock.

module tb_uart_tx_8n1;

`ifdef UART_TX_PARITY_EN
   localparam int NPER = 11;
`else
   localparam int NPER = 10;
`endif
   localparam int BIT = 434;

   logic       clk;
   logic       rst;
   logic       enable;
   logic       baud;
   logic [7:0] data;
   logic       valid;
   logic       ready;
   logic       tx;
   logic       busy;
   logic       done;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   uart_tx_8n1 dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_enable   (enable),
      .i_baud_clk (baud),
      .i_data     (data),
      .i_valid    (valid),
      .o_ready    (ready),
      .o_tx       (tx),
      .o_busy     (busy),
      .o_done     (done)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   initial begin
      baud = 1'b0;
      #5;
      forever #4340 baud = ~baud;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic exp_bit(input logic [7:0] b, input int k);
      if (k == 0) return 1'b0;
      if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
      if (k == 9) return ^b;
`endif
      return 1'b1;
   endfunction

   task automatic wait_start(input string tag, output int start_cyc, output bit ok);
      ok = 1'b0;
      start_cyc = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (tx === 1'b0) begin
            ok = 1'b1;
            start_cyc = cyc;
            break;
         end
      end
      chk({tag, "_start_seen"}, 32'(ok), 32'd1);
   endtask

   task automatic check_frame(input logic [7:0] b, input string tag, output int start_cyc);
      bit ok;
      wait_start(tag, start_cyc, ok);
      if (ok) begin
         for (int o = 0; o <= NPER*BIT + 1; o++) begin
            if (o > 0) @(negedge clk);
            if (o < NPER*BIT) begin
               if ((o % BIT == 0) || (o % BIT == BIT-1)) begin
                  chk($sformatf("%s_bit%0d_o%0d", tag, o/BIT, o), 32'(tx), 32'(exp_bit(b, o/BIT)));
                  chk({tag, "_busy"}, 32'(busy), 32'd1);
                  chk({tag, "_ready_low"}, 32'(ready), 32'd0);
                  chk({tag, "_done_low"}, 32'(done), 32'd0);
               end
            end else if (o == NPER*BIT) begin
               chk({tag, "_done_pulse"}, 32'(done), 32'd1);
               chk({tag, "_ready_in_done"}, 32'(ready), 32'd0);
            end else begin
               chk({tag, "_done_single"}, 32'(done), 32'd0);
               chk({tag, "_ready_after_done"}, 32'(ready), 32'd1);
            end
         end
      end
   endtask

   task automatic abort_frame(input logic [7:0] b, input bit use_rst, input string tag);
      int  sc;
      bit  ok;
      bit  seen;
      data  = b;
      valid = 1'b1;
      @(negedge clk);
      chk({tag, "_accept"}, 32'(busy), 32'd1);
      valid = 1'b0;
      wait_start(tag, sc, ok);
      repeat (5*BIT + 200) @(negedge clk);
      chk({tag, "_bit4"}, 32'(tx), 32'(b[4]));
      if (use_rst) rst = 1'b1;
      else         enable = 1'b0;
      @(negedge clk);
      chk({tag, "_tx_idle"}, 32'(tx), 32'd1);
      chk({tag, "_busy_low"}, 32'(busy), 32'd0);
      chk({tag, "_ready_low"}, 32'(ready), 32'd0);
      chk({tag, "_no_done"}, 32'(done), 32'd0);
      rst    = 1'b0;
      enable = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         if (done !== 1'b0 || tx !== 1'b1) seen = 1'b1;
      end
      chk({tag, "_quiet_after"}, 32'(seen), 32'd0);
      chk({tag, "_ready_back"}, 32'(ready), 32'd1);
   endtask

   initial begin
      int s1, s2, s3;
      rst    = 1'b1;
      enable = 1'b1;
      valid  = 1'b0;
      data   = 8'h00;
      repeat (5) @(negedge clk);
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", 32'(ready), 32'd1);
      chk("post_rst_tx", 32'(tx), 32'd1);
      chk("post_rst_busy", 32'(busy), 32'd0);

      // Single byte 0x55.
      data  = 8'h55;
      valid = 1'b1;
      @(negedge clk);
      chk("b55_accept_busy", 32'(busy), 32'd1);
      chk("b55_accept_ready", 32'(ready), 32'd0);
      valid = 1'b0;
      check_frame(8'h55, "b55", s1);

      // Back-to-back 0xA3 then 0x0F with valid held.
      data  = 8'hA3;
      valid = 1'b1;
      @(negedge clk);
      chk("bA3_accept", 32'(busy), 32'd1);
      data = 8'h0F;
      check_frame(8'hA3, "bA3", s1);
      @(negedge clk);
      chk("b0F_accept", 32'(busy), 32'd1);
      valid = 1'b0;
      check_frame(8'h0F, "b0F", s2);
      chk("b2b_gap", 32'(s2 - s1), 32'(NPER*BIT + BIT));

      // 0xFF offered while 0x00 is in flight must be ignored.
      data  = 8'h00;
      valid = 1'b1;
      @(negedge clk);
      chk("b00_accept", 32'(busy), 32'd1);
      data = 8'hFF;
      check_frame(8'h00, "b00", s3);
      valid = 1'b0;
      @(negedge clk);
      chk("bFF_ignored_busy", 32'(busy), 32'd0);
      chk("bFF_ignored_tx", 32'(tx), 32'd1);

      // Aborts in data bit 4, then a clean frame.
      abort_frame(8'hA5, 1'b0, "abort_en");
      abort_frame(8'h81, 1'b1, "abort_rst");
      data  = 8'h3C;
      valid = 1'b1;
      @(negedge clk);
      chk("b3C_accept", 32'(busy), 32'd1);
      valid = 1'b0;
      check_frame(8'h3C, "b3C", s1);

`ifdef UART_TX_PARITY_EN
      data  = 8'h07;
      valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      check_frame(8'h07, "par07", s1);
      data  = 8'h03;
      valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      check_frame(8'h03, "par03", s1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
